// File: rtl/clkdiv_pkg.sv
// Shared definitions for the clock-divider configuration front-end.
package clkdiv_pkg;

    localparam int unsigned MIN_RATIO = 2;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } cfg_state_e;

endpackage

// File: rtl/clkdiv_phase_tracker.sv
// Mirror of the divider's phase counter; flags the last cycle of each divided period.
module clkdiv_phase_tracker #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] ratio,
    output logic             boundary_c
);

    logic [WIDTH-1:0] cnt_q;
    logic             at_last_c;

    // ratio-1 only matters while enabled, and ratio is always >= 2 then
    assign at_last_c  = (cnt_q == WIDTH'(ratio - WIDTH'(1)));
    assign boundary_c = en && at_last_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= at_last_c ? '0 : WIDTH'(cnt_q + WIDTH'(1));
        end
    end

endmodule

// File: rtl/clkdiv_cfg_sync.sv
// Applies ratio/enable updates to the clock divider only at divided-period boundaries.
module clkdiv_cfg_sync
    import clkdiv_pkg::*;
#(
    parameter int unsigned WIDTH     = 3,
    parameter int unsigned RST_RATIO = 2
) (
    input  logic             i_ref_clk,
    input  logic             i_rst,
    input  logic             i_cfg_valid,
    input  logic [WIDTH-1:0] i_cfg_ratio,
    input  logic             i_cfg_en,
    output logic             o_cfg_ready,
    output logic [WIDTH-1:0] o_div_ratio,
    output logic             o_clk_en,
    output logic             o_cfg_done,
    output logic             o_cfg_err
);

    cfg_state_e       state_q, state_d;
    logic [WIDTH-1:0] ratio_q, ratio_d;
    logic [WIDTH-1:0] shadow_ratio_q, shadow_ratio_d;
    logic             clk_en_q, clk_en_d;
    logic             shadow_en_q, shadow_en_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             accept_c;
    logic             illegal_c;
    logic             boundary_c;
    logic             clr_c;

    assign o_cfg_ready = (state_q != PEND);
    assign accept_c    = i_cfg_valid && o_cfg_ready;
    assign illegal_c   = i_cfg_en && (i_cfg_ratio < WIDTH'(MIN_RATIO));

    clkdiv_phase_tracker #(
        .WIDTH (WIDTH)
    ) u_phase (
        .clk        (i_ref_clk),
        .rst        (i_rst),
        .en         (clk_en_q),
        .clr        (clr_c),
        .ratio      (ratio_q),
        .boundary_c (boundary_c)
    );

    // Next-state and next-output decode
    always_comb begin
        state_d        = state_q;
        ratio_d        = ratio_q;
        clk_en_d       = clk_en_q;
        shadow_ratio_d = shadow_ratio_q;
        shadow_en_d    = shadow_en_q;
        done_d         = 1'b0;
        err_d          = 1'b0;
        clr_c          = 1'b0;

        if (accept_c && illegal_c) begin
            err_d = 1'b1;
        end else begin
            case (state_q)
                OFF: begin
                    if (accept_c) begin
                        ratio_d  = i_cfg_ratio;
                        clk_en_d = i_cfg_en;
                        clr_c    = 1'b1;
                        done_d   = 1'b1;
                        state_d  = i_cfg_en ? RUN : OFF;
                    end
                end
                RUN: begin
                    // A request on the boundary cycle waits for the following boundary
                    if (accept_c) begin
                        shadow_ratio_d = i_cfg_ratio;
                        shadow_en_d    = i_cfg_en;
                        state_d        = PEND;
                    end
                end
                PEND: begin
                    if (boundary_c) begin
                        ratio_d  = shadow_ratio_q;
                        clk_en_d = shadow_en_q;
                        clr_c    = 1'b1;
                        done_d   = 1'b1;
                        state_d  = shadow_en_q ? RUN : OFF;
                    end
                end
                default: begin
                    state_d = OFF;
                end
            endcase
        end
    end

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= OFF;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            ratio_q        <= WIDTH'(RST_RATIO);
            clk_en_q       <= 1'b0;
            shadow_ratio_q <= '0;
            shadow_en_q    <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            ratio_q        <= ratio_d;
            clk_en_q       <= clk_en_d;
            shadow_ratio_q <= shadow_ratio_d;
            shadow_en_q    <= shadow_en_d;
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end

    assign o_div_ratio = ratio_q;
    assign o_clk_en    = clk_en_q;
    assign o_cfg_done  = done_q;
    assign o_cfg_err   = err_q;

endmodule

// File: tb/tb_clkdiv_cfg_sync.sv
// Directed self-checking bench for clkdiv_cfg_sync.
module tb_clkdiv_cfg_sync;

    logic       clk;
    logic       rst;
    logic       cfg_valid;
    logic [2:0] cfg_ratio;
    logic       cfg_en;
    logic       cfg_ready;
    logic [2:0] div_ratio;
    logic       clk_en;
    logic       cfg_done;
    logic       cfg_err;

    int checks = 0;
    int errors = 0;

    clkdiv_cfg_sync #(
        .WIDTH     (3),
        .RST_RATIO (2)
    ) dut (
        .i_ref_clk   (clk),
        .i_rst       (rst),
        .i_cfg_valid (cfg_valid),
        .i_cfg_ratio (cfg_ratio),
        .i_cfg_en    (cfg_en),
        .o_cfg_ready (cfg_ready),
        .o_div_ratio (div_ratio),
        .o_clk_en    (clk_en),
        .o_cfg_done  (cfg_done),
        .o_cfg_err   (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] ratio, input logic en);
        cfg_valid = 1'b1;
        cfg_ratio = ratio;
        cfg_en    = en;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL reset_clk_en: got %0b expected 0", clk_en); end
        checks++; if (div_ratio !== 3'd2) begin errors++; $display("FAIL reset_ratio: got %0d expected 2", div_ratio); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", cfg_ready); end
        checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", cfg_done); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", cfg_err); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load_from_off();
        send(3'd4, 1'b1);
        checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL load_clk_en: got %0b expected 1", clk_en); end
        checks++; if (div_ratio !== 3'd4) begin errors++; $display("FAIL load_ratio: got %0d expected 4", div_ratio); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL load_ready: got %0b expected 1", cfg_ready); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (cfg_done !== (i == 0)) begin errors++; $display("FAIL load_done_%0d: got %0b expected %0b", i, cfg_done, (i == 0)); end
            checks++; if (dut.u_phase.boundary_c !== (i % 4 == 3)) begin errors++; $display("FAIL load_boundary_%0d: got %0b expected %0b", i, dut.u_phase.boundary_c, (i % 4 == 3)); end
            tick();
        end
    endtask

    task automatic test_retune();
        tick();
        cfg_valid = 1'b1;
        cfg_ratio = 3'd6;
        cfg_en    = 1'b1;
        tick();
        // Competing request while pending must be ignored
        cfg_ratio = 3'd3;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL retune_ready_a: got %0b expected 0", cfg_ready); end
        checks++; if (div_ratio !== 3'd4) begin errors++; $display("FAIL retune_ratio_a: got %0d expected 4", div_ratio); end
        checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL retune_done_a: got %0b expected 0", cfg_done); end
        tick();
        cfg_valid = 1'b0;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL retune_ready_b: got %0b expected 0", cfg_ready); end
        checks++; if (div_ratio !== 3'd4) begin errors++; $display("FAIL retune_ratio_b: got %0d expected 4", div_ratio); end
        tick();
        checks++; if (div_ratio !== 3'd6) begin errors++; $display("FAIL retune_ratio_c: got %0d expected 6", div_ratio); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL retune_ready_c: got %0b expected 1", cfg_ready); end
        checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL retune_clk_en: got %0b expected 1", clk_en); end
        for (int i = 0; i < 12; i++) begin
            checks++; if (cfg_done !== (i == 0)) begin errors++; $display("FAIL retune_done_%0d: got %0b expected %0b", i, cfg_done, (i == 0)); end
            checks++; if (dut.u_phase.boundary_c !== (i % 6 == 5)) begin errors++; $display("FAIL retune_boundary_%0d: got %0b expected %0b", i, dut.u_phase.boundary_c, (i % 6 == 5)); end
            tick();
        end
    endtask

    task automatic test_illegal();
        send(3'd1, 1'b1);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL illegal_err: got %0b expected 1", cfg_err); end
        checks++; if (div_ratio !== 3'd6) begin errors++; $display("FAIL illegal_ratio: got %0d expected 6", div_ratio); end
        checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL illegal_clk_en: got %0b expected 1", clk_en); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready: got %0b expected 1", cfg_ready); end
        checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL illegal_done: got %0b expected 0", cfg_done); end
        tick();
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL illegal_err_clear: got %0b expected 0", cfg_err); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready_b: got %0b expected 1", cfg_ready); end
    endtask

    task automatic test_reset_mid_run();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL midrst_clk_en: got %0b expected 0", clk_en); end
        checks++; if (div_ratio !== 3'd2) begin errors++; $display("FAIL midrst_ratio: got %0d expected 2", div_ratio); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %0b expected 1", cfg_ready); end
        checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %0b expected 0", cfg_done); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %0b expected 0", cfg_err); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_disable();
        send(3'd5, 1'b1);
        tick();
        send(3'd3, 1'b0);
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL dis_ready: got %0b expected 0", cfg_ready); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (clk_en !== (i != 3)) begin errors++; $display("FAIL dis_clk_en_%0d: got %0b expected %0b", i, clk_en, (i != 3)); end
            checks++; if (cfg_done !== (i == 3)) begin errors++; $display("FAIL dis_done_%0d: got %0b expected %0b", i, cfg_done, (i == 3)); end
        end
        checks++; if (div_ratio !== 3'd3) begin errors++; $display("FAIL dis_ratio: got %0d expected 3", div_ratio); end
        // In OFF a disabled request is applied on the very next edge
        send(3'd2, 1'b0);
        checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL dis_off_done: got %0b expected 1", cfg_done); end
        checks++; if (div_ratio !== 3'd2) begin errors++; $display("FAIL dis_off_ratio: got %0d expected 2", div_ratio); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL dis_off_ready: got %0b expected 1", cfg_ready); end
    endtask

    task automatic test_back_to_back();
        send(3'd4, 1'b1);
        tick();
        tick();
        tick();
        checks++; if (dut.u_phase.boundary_c !== 1'b1) begin errors++; $display("FAIL b2b_on_boundary: got %0b expected 1", dut.u_phase.boundary_c); end
        send(3'd2, 1'b1);
        checks++; if (div_ratio !== 3'd4) begin errors++; $display("FAIL b2b_ratio_hold: got %0d expected 4", div_ratio); end
        checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL b2b_done_hold: got %0b expected 0", cfg_done); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready: got %0b expected 0", cfg_ready); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++; if (cfg_done !== (i == 4)) begin errors++; $display("FAIL b2b_done_%0d: got %0b expected %0b", i, cfg_done, (i == 4)); end
            checks++; if (div_ratio !== ((i == 4) ? 3'd2 : 3'd4)) begin errors++; $display("FAIL b2b_ratio_%0d: got %0d expected %0d", i, div_ratio, ((i == 4) ? 2 : 4)); end
        end
    endtask

    task automatic test_reset_in_pend();
        send(3'd7, 1'b1);
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rpend_ready_a: got %0b expected 0", cfg_ready); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rpend_ready_b: got %0b expected 1", cfg_ready); end
        checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL rpend_clk_en: got %0b expected 0", clk_en); end
        rst = 1'b0;
        repeat (4) tick();
        checks++; if (div_ratio !== 3'd2) begin errors++; $display("FAIL rpend_ratio: got %0d expected 2", div_ratio); end
        checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL rpend_done: got %0b expected 0", cfg_done); end
        send(3'd0, 1'b1);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL rpend_off_err: got %0b expected 1", cfg_err); end
        checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL rpend_off_clk_en: got %0b expected 0", clk_en); end
        checks++; if (div_ratio !== 3'd2) begin errors++; $display("FAIL rpend_off_ratio: got %0d expected 2", div_ratio); end
    endtask

    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_ratio = 3'd0;
        cfg_en    = 1'b0;
        test_reset();
        test_load_from_off();
        test_retune();
        test_illegal();
        test_reset_mid_run();
        test_disable();
        test_back_to_back();
        test_reset_in_pend();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
